// File: rtl/inv_subbytes_seq_if.sv
// Handshake bundle between the InvShiftRows stage, the InvSubBytes sequencer and InvMixColumns.
// The master drives the input state and output acceptance; the slave is the sequencer.
// Byte j of either state is bits [127-8j -: 8].
interface inv_subbytes_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   modport master (
      output in_valid, in_state, out_ready,
      input  in_ready, out_valid, out_state, busy
   );

   modport slave (
      input  in_valid, in_state, out_ready,
      output in_ready, out_valid, out_state, busy
   );
endinterface

// File: rtl/inv_subbytes_seq.sv
// Purpose: AES InvSubBytes over one 128-bit state, 16 bytes time-multiplexed through LANES inverse S-boxes.
// Latency: N = 16/LANES cycles from the accept edge to out_valid; II is N+2 (N+1 with overlap).
// Backpressure: in_ready is low while busy; the result holds in DONE until out_ready.
// Optional feature macro: INVSUB_OVERLAP_EN lets a new state be accepted on the output handshake edge.

// Combinational AES inverse S-box: inverse affine transform followed by the GF(2^8) inverse.
module InverseSbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] r;
      sq = x;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   logic [7:0] aff;

   // Undo the forward affine map, then invert in the field.
   always_comb begin
      aff   = {in_i[6:0], in_i[7]} ^ {in_i[4:0], in_i[7:5]} ^ {in_i[1:0], in_i[7:2]} ^ 8'h05;
      out_o = ginv(aff);
   end
endmodule

module inv_subbytes_seq #(
   parameter int LANES = 4
) (
   input logic               clk,
   input logic               rst,
   inv_subbytes_seq_if.slave bus
);
   localparam int N  = 16 / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [127:0]    src_q,   src_d;
   logic [127:0]    res_q,   res_d;

   logic            in_rdy;
   logic            out_vld;

   logic [7:0]      lane_in  [LANES];
   logic [7:0]      lane_out [LANES];
   logic [6:0]      lane_sh  [LANES];

   // Lane l works on byte cnt*LANES+l; byte k sits at bit offset 8*(15-k).
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_sh[l] = 7'((15 - (int'(cnt_q) * LANES + l)) * 8);
         lane_in[l] = src_q[lane_sh[l] +: 8];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      InverseSbox u_sbox (
         .in_i  (lane_in[g]),
         .out_o (lane_out[g])
      );
   end

   // Next-state, datapath update and handshake decode; outputs depend on state (plus out_ready with overlap).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      src_d   = src_q;
      res_d   = res_q;
      in_rdy  = 1'b0;
      out_vld = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_rdy = ~rst;
            if (bus.in_valid) begin
               src_d   = bus.in_state;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int l = 0; l < LANES; l++) begin
               res_d[lane_sh[l] +: 8] = lane_out[l];
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) state_d = DONE;
         end
         DONE: begin
            out_vld = 1'b1;
`ifdef INVSUB_OVERLAP_EN
            in_rdy = bus.out_ready & ~rst;
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  src_d   = bus.in_state;
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
`else
            if (bus.out_ready) state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any block in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         src_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         res_q   <= res_d;
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.out_state = res_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/inv_subbytes_seq.md
# inv_subbytes_seq

Sequencer for the AES-256 decryption datapath's InvSubBytes step. It takes one 128-bit state over a valid/ready handshake and time-multiplexes the 16 bytes through `LANES` instances of the combinational `InverseSbox` module. It returns the substituted state over a second valid/ready handshake. It sits between the round-key/InvShiftRows stage and the InvMixColumns stage, and trades S-box area against latency.

## Interface
- `LANES`, default 4: number of `InverseSbox` instances.
  - Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
  - `N = 16/LANES` is the number of substitution cycles per block.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset; one clock; synchronous, active-high.
- `in_valid` input 1: upstream state valid.
- `in_ready` output 1: block can accept a state.
- `in_state` input 128: state in. Byte j is `in_state[127-8j -: 8]`, for j = 0..15.
- `out_valid` output 1: substituted state available.
- `out_ready` input 1: downstream accepts.
- `out_state` output 128: substituted state, same byte order as `in_state`.
- `busy` output 1: high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready = 1`.
  - On `in_valid && in_ready`: latch `in_state` into the source register, clear `cnt` (width log2(N), minimum 1 bit), go to RUN.
- **RUN**
  - Each cycle, lane l (0..LANES-1) substitutes byte `k = cnt*LANES + l`.
  - The result is written into byte k of the result register.
  - `cnt` increments.
  - When `cnt == N-1`, go to DONE on that edge.
  - `in_ready = 0`.
- **DONE**
  - `out_valid = 1` and `out_state` = result register.
  - Both hold stable until `out_ready` is sampled high, then go to IDLE.
- Bytes not yet processed retain their previous result-register value. `out_state` is only meaningful while `out_valid = 1`.
- `busy = (state != IDLE)`.
- `in_ready` is decoded from state and is forced 0 while `rst = 1`.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.
- Source byte mux indexing uses the `cnt` value; no wrap occurs because the transition to DONE happens at `cnt == N-1`.

## Timing
- Accept edge E0.
  - Bytes are written on edges E1..EN.
  - `out_valid` is high from EN onward, so latency is N cycles.
  - Example: LANES=4 gives 4 cycles; LANES=16 gives 1 cycle.
- The output handshake completes on the edge where `out_valid && out_ready`.
  - `in_ready` is high on the following cycle.
  - Minimum initiation interval is N+2 cycles without overlap.
- Reset values:
  - state IDLE, `cnt` 0, `out_valid` 0, `busy` 0.
  - `out_state` 128'h0 (source and result registers cleared).
  - `in_ready` is 0 during `rst`, 1 from the first cycle after `rst` deasserts.
- Reset mid-RUN or mid-DONE: the block is abandoned with no output.
  - `out_valid` drops on the reset edge.
  - A pending `out_ready` is ignored.
- `in_valid` while not ready: ignored. Upstream holds the data.

## Configuration
- `INVSUB_OVERLAP_EN`
  - **Defined:** in DONE, `in_ready = out_ready`. On an edge with `out_valid && out_ready && in_valid`, the block latches the new `in_state`, clears `cnt` and goes directly to RUN. `in_ready` then depends combinationally on `out_ready`. Initiation interval is N+1.
  - **Undefined:** behaviour exactly as specified above; `in_ready` is 0 in DONE.

## Test plan
- LANES=4, `in_state` = 128'h0, `out_ready` = 1 -> `out_valid` high 4 cycles after the accept edge, `out_state` = 128'h52525252525252525252525252525252.
- LANES=4, `in_state` = 128'h000102030405060708090a0b0c0d0e0f -> `out_state` = 128'h52096ad53036a538bf40a39e81f3d7fb.
- LANES=1 and LANES=16 with the same vector -> identical `out_state`, latency 16 and 1 cycles respectively.
- `out_ready` held low 10 cycles in DONE -> `out_valid` = 1 and `out_state` stable, `in_ready` = 0 and `busy` = 1 throughout; IDLE one cycle after `out_ready` rises.
- Reset pulse at RUN cycle 2 with `in_state` all 0x63 -> `out_valid` = 0, `out_state` = 0, `in_ready` = 1 after reset. Next block of all 0x63 -> all 0x00.
- Two back-to-back blocks, `out_ready` = 1:
  - Without `INVSUB_OVERLAP_EN`, second accept 2 cycles after first `out_valid`.
  - With it, second accept on the first output-handshake edge, and outputs are spaced N+1 cycles apart.
